// File: rtl/mano_ctrl_seq.sv
// Timing and control sequencer for the 16-bit basic-computer datapath.
// Steps SC through fetch, decode and the memory-reference instructions and
// decodes the registered step into the register-file, bus, ALU and memory strobes.
module mano_ctrl_seq #(
    parameter logic        AUTO_START = 1'b0,
    parameter logic [15:0] HLT_CODE   = 16'h7001
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [15:0] IR_IN,
    input  logic        DR_ZERO,
    output logic [2:0]  BUS_SEL,
    output logic        AR_LD,
    output logic        AR_INR,
    output logic        PC_LD,
    output logic        PC_INR,
    output logic        DR_LD,
    output logic        DR_INR,
    output logic        IR_LD,
    output logic        AC_LD,
    output logic [1:0]  ALU_OP,
    output logic        MEM_RD,
    output logic        MEM_WE,
    output logic        RUN,
    output logic [3:0]  SC
);

    localparam int unsigned ScW = 4;

    localparam logic [2:0] BusNone = 3'd0;
    localparam logic [2:0] BusAr   = 3'd1;
    localparam logic [2:0] BusPc   = 3'd2;
    localparam logic [2:0] BusDr   = 3'd3;
    localparam logic [2:0] BusAc   = 3'd4;
    localparam logic [2:0] BusIr   = 3'd5;
    localparam logic [2:0] BusMem  = 3'd7;

    localparam logic [1:0] AluPass = 2'd0;
    localparam logic [1:0] AluAnd  = 2'd1;
    localparam logic [1:0] AluAdd  = 2'd2;

    typedef enum logic {
        Halted  = 1'b0,
        Running = 1'b1
    } runState_t;

    runState_t        runState, runNext;
    logic [ScW-1:0]   sc, scNext;
    logic             iLat, iNext;
    logic [2:0]       dLat, dNext;

    // State register: run flag, sequence counter and latched I/D fields.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            runState <= AUTO_START ? Running : Halted;
            sc       <= '0;
            iLat     <= 1'b0;
            dLat     <= 3'd0;
        end else begin
            runState <= runNext;
            sc       <= scNext;
            iLat     <= iNext;
            dLat     <= dNext;
        end
    end

    // Next-step sequencing and per-step strobe decode.
    always_comb begin
        runNext = runState;
        scNext  = sc;
        iNext   = iLat;
        dNext   = dLat;
        BUS_SEL = BusNone;
        AR_LD   = 1'b0;
        AR_INR  = 1'b0;
        PC_LD   = 1'b0;
        PC_INR  = 1'b0;
        DR_LD   = 1'b0;
        DR_INR  = 1'b0;
        IR_LD   = 1'b0;
        AC_LD   = 1'b0;
        ALU_OP  = AluPass;
        MEM_RD  = 1'b0;
        MEM_WE  = 1'b0;

        case (runState)
            Halted: begin
                if (START) begin
                    runNext = Running;
                    scNext  = '0;
                end
            end
            Running: begin
                scNext = sc + ScW'(1);
                case (sc)
                    4'd0: begin
                        BUS_SEL = BusPc;
                        AR_LD   = 1'b1;
                    end
                    4'd1: begin
                        MEM_RD  = 1'b1;
                        BUS_SEL = BusMem;
                        IR_LD   = 1'b1;
                        PC_INR  = 1'b1;
                    end
                    4'd2: begin
                        BUS_SEL = BusIr;
                        AR_LD   = 1'b1;
                        iNext   = IR_IN[15];
                        dNext   = IR_IN[14:12];
                    end
                    4'd3: begin
                        if (dLat == 3'd7) begin
                            if (IR_IN == HLT_CODE) runNext = Halted;
                            scNext = '0;
                        end else if (iLat) begin
                            MEM_RD  = 1'b1;
                            BUS_SEL = BusMem;
                            AR_LD   = 1'b1;
                        end
                    end
                    4'd4: begin
                        case (dLat)
                            3'd0, 3'd1, 3'd2, 3'd6: begin
                                MEM_RD  = 1'b1;
                                BUS_SEL = BusMem;
                                DR_LD   = 1'b1;
                            end
                            3'd3: begin
                                BUS_SEL = BusAc;
                                MEM_WE  = 1'b1;
                                scNext  = '0;
                            end
                            3'd4: begin
                                BUS_SEL = BusAr;
                                PC_LD   = 1'b1;
                                scNext  = '0;
                            end
                            3'd5: begin
                                BUS_SEL = BusPc;
                                MEM_WE  = 1'b1;
                                AR_INR  = 1'b1;
                            end
                            default: scNext = '0;
                        endcase
                    end
                    4'd5: begin
                        case (dLat)
                            3'd0: begin
                                AC_LD  = 1'b1;
                                ALU_OP = AluAnd;
                                scNext = '0;
                            end
                            3'd1: begin
                                AC_LD  = 1'b1;
                                ALU_OP = AluAdd;
                                scNext = '0;
                            end
                            3'd2: begin
                                AC_LD  = 1'b1;
                                ALU_OP = AluPass;
                                scNext = '0;
                            end
                            3'd5: begin
                                BUS_SEL = BusAr;
                                PC_LD   = 1'b1;
                                scNext  = '0;
                            end
                            3'd6: DR_INR = 1'b1;
                            default: scNext = '0;
                        endcase
                    end
                    4'd6: begin
                        if (dLat == 3'd6) begin
                            BUS_SEL = BusDr;
                            MEM_WE  = 1'b1;
                            PC_INR  = DR_ZERO;
                        end
                        scNext = '0;
                    end
                    // Illegal steps recover to T0 with no strobes.
                    default: scNext = '0;
                endcase
            end
            default: begin
                runNext = Halted;
                scNext  = '0;
            end
        endcase
    end

    assign RUN = (runState == Running);
    assign SC  = sc;

endmodule

// File: tb/tb_mano_ctrl_seq.sv
// Randomized bench for mano_ctrl_seq against an instruction-level reference model.
module tb_mano_ctrl_seq;

    localparam logic [15:0] HltCode = 16'h7001;

    logic        CLK, RST_N, START, DR_ZERO;
    logic [15:0] IR_IN;
    logic [2:0]  BUS_SEL;
    logic        AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR, IR_LD, AC_LD;
    logic [1:0]  ALU_OP;
    logic        MEM_RD, MEM_WE, RUN;
    logic [3:0]  SC;

    mano_ctrl_seq #(.AUTO_START(1'b0), .HLT_CODE(HltCode)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .IR_IN(IR_IN), .DR_ZERO(DR_ZERO),
        .BUS_SEL(BUS_SEL), .AR_LD(AR_LD), .AR_INR(AR_INR), .PC_LD(PC_LD),
        .PC_INR(PC_INR), .DR_LD(DR_LD), .DR_INR(DR_INR), .IR_LD(IR_LD),
        .AC_LD(AC_LD), .ALU_OP(ALU_OP), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE),
        .RUN(RUN), .SC(SC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: run flag, position within the current instruction, latched fields.
    logic        mRun = 1'b0;
    int          mStep = 0;
    logic        mI = 1'b0;
    int          mD = 0;
    logic [15:0] curIr = 16'h0;
    int          curDzSel = -1;
    logic        checking = 1'b0;
    logic        bsaRstDone = 1'b0;

    logic [15:0] dirIr[$];
    int          dirDz[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Cycles from T0 back to T0 for each decoded opcode.
    function automatic int instrLen(input int d);
        case (d)
            0, 1, 2, 5: return 6;
            3, 4:       return 5;
            6:          return 7;
            default:    return 4;
        endcase
    endfunction

    // Expected strobes packed as {bus, arLd, arInr, pcLd, pcInr, drLd, drInr, irLd, acLd, alu, memRd, memWe}.
    function automatic logic [14:0] pack(input logic [2:0] bus, input logic arLd, input logic arInr,
                                         input logic pcLd, input logic pcInr, input logic drLd,
                                         input logic drInr, input logic irLd, input logic acLd,
                                         input logic [1:0] alu, input logic memRd, input logic memWe);
        return {bus, arLd, arInr, pcLd, pcInr, drLd, drInr, irLd, acLd, alu, memRd, memWe};
    endfunction

    function automatic logic [14:0] expOps(input logic run, input int step, input logic i,
                                           input int d, input logic drz);
        logic [14:0] v;
        v = '0;
        if (run) begin
            case (step)
                0: v = pack(3'd2, 1,0,0,0,0,0,0,0, 2'd0, 0,0);
                1: v = pack(3'd7, 0,0,0,1,0,0,1,0, 2'd0, 1,0);
                2: v = pack(3'd5, 1,0,0,0,0,0,0,0, 2'd0, 0,0);
                3: if (d != 7 && i) v = pack(3'd7, 1,0,0,0,0,0,0,0, 2'd0, 1,0);
                4: case (d)
                       0, 1, 2, 6: v = pack(3'd7, 0,0,0,0,1,0,0,0, 2'd0, 1,0);
                       3:          v = pack(3'd4, 0,0,0,0,0,0,0,0, 2'd0, 0,1);
                       4:          v = pack(3'd1, 0,0,1,0,0,0,0,0, 2'd0, 0,0);
                       5:          v = pack(3'd2, 0,1,0,0,0,0,0,0, 2'd0, 0,1);
                       default:    v = '0;
                   endcase
                5: case (d)
                       0:       v = pack(3'd0, 0,0,0,0,0,0,0,1, 2'd1, 0,0);
                       1:       v = pack(3'd0, 0,0,0,0,0,0,0,1, 2'd2, 0,0);
                       2:       v = pack(3'd0, 0,0,0,0,0,0,0,1, 2'd0, 0,0);
                       5:       v = pack(3'd1, 0,0,1,0,0,0,0,0, 2'd0, 0,0);
                       6:       v = pack(3'd0, 0,0,0,0,0,1,0,0, 2'd0, 0,0);
                       default: v = '0;
                   endcase
                6: if (d == 6) v = pack(3'd3, 0,0,0,drz,0,0,0,0, 2'd0, 0,1);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic modelEdge(input logic rstn, input logic start, input logic [15:0] ir);
        if (!rstn) begin
            mRun = 1'b0; mStep = 0; mI = 1'b0; mD = 0;
        end else if (!mRun) begin
            if (start) begin mRun = 1'b1; mStep = 0; end
        end else begin
            if (mStep == 2) begin mI = ir[15]; mD = int'(ir[14:12]); end
            if (mStep == 3 && mD == 7 && ir == HltCode) mRun = 1'b0;
            mStep = (mStep == instrLen(mD) - 1) ? 0 : mStep + 1;
        end
    endtask

    task automatic pickInstr();
        int d;
        if (dirIr.size() > 0) begin
            curIr    = dirIr.pop_front();
            curDzSel = dirDz.pop_front();
        end else begin
            d = $urandom_range(0, 7);
            if (d == 7 && $urandom_range(0, 1) == 1) curIr = HltCode;
            else curIr = {1'($urandom_range(0, 1)), 3'(d), 12'($urandom)};
            curDzSel = -1;
        end
    endtask

    task automatic doCycle(input logic rstn, input logic start);
        logic [14:0] got;
        @(negedge CLK);
        if (mRun && mStep == 0) pickInstr();
        RST_N   = rstn;
        START   = start;
        IR_IN   = curIr;
        DR_ZERO = (curDzSel >= 0) ? curDzSel[0] : 1'($urandom_range(0, 1));
        #1;
        if (checking) begin
            got = {BUS_SEL, AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR, IR_LD, AC_LD,
                   ALU_OP, MEM_RD, MEM_WE};
            checkVal("RUN", 32'(RUN), 32'(mRun));
            checkVal("SC", 32'(SC), 32'(mStep));
            checkVal($sformatf("ops step%0d d%0d i%0d", mStep, mD, mI), 32'(got),
                     32'(expOps(mRun, mStep, mI, mD, DR_ZERO)));
        end
        @(posedge CLK);
        modelEdge(rstn, start, IR_IN);
        checking = 1'b1;
    endtask

    initial begin
        logic rst, st;
        RST_N = 1'b0; START = 1'b0; IR_IN = 16'h0; DR_ZERO = 1'b0;
        dirIr = '{16'h1123, 16'hB200, 16'h6050, 16'h6050, 16'h7001};
        dirDz = '{-1, -1, 1, 0, -1};

        doCycle(1'b0, 1'b0);
        doCycle(1'b0, 1'b1);
        doCycle(1'b1, 1'b0);
        doCycle(1'b1, 1'b1);

        for (int n = 0; n < 4000; n++) begin
            rst = 1'b1;
            if (!bsaRstDone && mRun && mStep == 4 && mD == 5) begin
                rst = 1'b0;
                bsaRstDone = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
            end
            st = mRun ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            doCycle(rst, st);
        end

        checkVal("bsa reset exercised", 32'(bsaRstDone), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mano_ctrl_seq.md
Name: mano_ctrl_seq

Overview:
- Timing and control sequencer for the 16-bit basic-computer datapath (AR, PC, DR, AC, IR, memory, common bus).
- Runs a 4-bit sequence counter (SC, T0..T6) that steps through instruction fetch, decode and the memory-reference instructions AND, ADD, LDA, STA, BUN, BSA and ISZ, plus HLT.
- Each cycle it drives the LD/INR strobes, the bus select, the ALU op and the memory strobes that make the register file perform that cycle's transfer.

Parameters:
- AUTO_START, 0: value RUN takes at reset (1 = begin fetching immediately).
- HLT_CODE, 16'h7001: IR value decoded as halt.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  reset: synchronous, active-low.
- START  in  1  begin execution when halted.
- IR_IN  in  16  current IR register contents.
- DR_ZERO  in  1  high when DR == 16'h0000 (combinational from DR).
- BUS_SEL  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 memory.
- AR_LD, AR_INR  out  1 each  AR load / increment.
- PC_LD, PC_INR  out  1 each  PC load / increment.
- DR_LD, DR_INR  out  1 each  DR load / increment.
- IR_LD  out  1  IR load from bus.
- AC_LD  out  1  AC load from ALU.
- ALU_OP  out  2  0 pass DR, 1 AND, 2 ADD (E <- carry).
- MEM_RD, MEM_WE  out  1 each  memory read at AR / write bus to M[AR].
- RUN  out  1  execution flag.
- SC  out  4  current timing step.

Behaviour:
- Reset when RST_N=0 at a clock edge: SC=0, RUN=AUTO_START, latched I=0, latched D=0. Reset overrides START and any in-flight instruction; no partial transfer completes.
- All outputs are combinational decode of the registered SC, I, D and RUN. When RUN=0, every strobe is 0, BUS_SEL=0 and ALU_OP=0.
- START=1 while RUN=0: RUN becomes 1 and SC becomes 0 on the next edge. START while RUN=1 is ignored.
- SC increments each cycle while RUN=1. "SC<-0" means the next edge loads 0 instead of incrementing.
- T0: BUS_SEL=2, AR_LD.
- T1: MEM_RD, BUS_SEL=7, IR_LD, PC_INR.
- T2: BUS_SEL=5, AR_LD (AR takes IR[11:0]). On the edge, latch I<=IR_IN[15] and D<=IR_IN[14:12].
- T3, D==7: if IR_IN==HLT_CODE, RUN<=0; always SC<-0. All other register-reference codes are NOPs.
- T3, D!=7, I=1: MEM_RD, BUS_SEL=7, AR_LD (indirect fetch).
- T3, D!=7, I=0: no strobes.
- AND (D=0), ADD (D=1), LDA (D=2):
  - T4: MEM_RD, BUS_SEL=7, DR_LD.
  - T5: AC_LD with ALU_OP = 1 / 2 / 0 respectively; SC<-0.
- STA (D=3), T4: BUS_SEL=4, MEM_WE; SC<-0.
- BUN (D=4), T4: BUS_SEL=1, PC_LD; SC<-0.
- BSA (D=5):
  - T4: BUS_SEL=2, MEM_WE, AR_INR.
  - T5: BUS_SEL=1, PC_LD; SC<-0.
- ISZ (D=6):
  - T4: MEM_RD, BUS_SEL=7, DR_LD.
  - T5: DR_INR.
  - T6: BUS_SEL=3, MEM_WE; PC_INR iff DR_ZERO; SC<-0.
- Invariants:
  - At most one bus source per cycle.
  - MEM_RD and MEM_WE are never both high.
  - SC never exceeds 6; if SC reaches 7..15, force SC<-0 next edge with no strobes.
- ISZ wrap: DR=16'hFFFF incremented at T5 becomes 0, so DR_ZERO=1 at T6 and the skip is taken.
- Per-instruction length (T0 to return to T0): AND/ADD/LDA 6 cycles; STA/BUN 5; BSA 6; ISZ 7; HLT 4.

Test Plan:
- Reset with AUTO_START=0 -> SC=0, RUN=0, all strobes 0. Pulse START -> next cycle RUN=1, SC=0; T0 shows BUS_SEL=2, AR_LD=1.
- IR_IN=16'h1123 (ADD, direct) -> T2 AR_LD with BUS_SEL=5; T3 no strobes; T4 MEM_RD, DR_LD; T5 AC_LD, ALU_OP=2; next SC=0.
- IR_IN=16'hB200 (STA, indirect) -> T3 MEM_RD, BUS_SEL=7, AR_LD; T4 BUS_SEL=4, MEM_WE; 5 cycles total.
- IR_IN=16'h6050 (ISZ) with DR_ZERO=1 at T6 -> T6 MEM_WE, BUS_SEL=3, PC_INR=1. Repeat with DR_ZERO=0 -> PC_INR=0.
- IR_IN=16'h7001 -> RUN falls after T3, SC=0, strobes stay 0. START while running is ignored; START after the halt restarts at T0.
- Assert RST_N=0 during BSA T4 -> next edge SC=0, RUN=AUTO_START, no MEM_WE or PC_LD follows.
